// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch controller.
// State encoding, word size and the buffered-entry layout.
package ifetch_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IF_XLEN    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [IF_XLEN-1:0] data;
    logic [IF_XLEN-1:0] pc;
    logic               fault;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO for fetched words.
// Ports: push/pop/flush, din/dout, count, full, empty.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues reads to
// i_memory, buffers words, handles redirects and faults.
import ifetch_pkg::*;

module ifetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_fault,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(ifetch_entry_t);

  // One extra bit keeps the limit from wrapping.
  localparam logic [ADDR_WIDTH:0] LO =
    {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI =
    LO + (ADDR_WIDTH+1)'(MEM_DEPTH * WORD_BYTES);

  ifetch_state_t   state;
  ifetch_state_t   state_nxt;
  logic            pend;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic            pend_fault;
  logic            addr_fault;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     need;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  ifetch_entry_t   push_e;
  ifetch_entry_t   head_e;

  assign addr_fault =
    ({1'b0, mem_addr} < LO) ||
    ({1'b0, mem_addr} >= HI);

  assign pop  = instr_valid && instr_ready;
  assign push = pend && !redirect_valid;

  // Slots claimed once this cycle's pop retires.
  assign need = {1'b0, fifo_count}
              + (CW+1)'(pend)
              - (CW+1)'(pop);

  assign issue = (state == RUN) && enable
              && !redirect_valid
              && (need < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    push_e       = '0;
    push_e.pc    = IF_XLEN'(pend_pc);
    push_e.fault = pend_fault;
    push_e.data  = pend_fault ? '0
                 : IF_XLEN'(mem_rdata);
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = enable ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE:    if (enable) state_nxt = RUN;
        RUN: begin
          if (!enable)
            state_nxt = IDLE;
          else if (issue && addr_fault)
            state_nxt = FAULT;
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_addr   <= RESET_PC;
      pend       <= 1'b0;
      pend_pc    <= '0;
      pend_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        mem_addr <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        pend     <= 1'b0;
      end else if (issue) begin
        mem_addr   <= mem_addr
                    + ADDR_WIDTH'(WORD_BYTES);
        pend       <= 1'b1;
        pend_pc    <= mem_addr;
        pend_fault <= addr_fault;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     (push_e),
    .dout    (head_e),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = instr_valid
                     ? DATA_WIDTH'(head_e.data) : '0;
  assign instr_pc    = instr_valid
                     ? ADDR_WIDTH'(head_e.pc) : '0;
  assign instr_fault = instr_valid && head_e.fault;
  assign busy        = (fifo_count != '0) | pend;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sequences reads from the single-port instruction memory (`i_memory`, registered read, 1-cycle latency) and delivers a valid/ready instruction stream to the core. It owns the fetch PC, issues one word-aligned read per cycle when buffer credit allows, and buffers returned words in a small FIFO. It also handles core redirects (branch/jump/trap) and stops on out-of-range fetch addresses. It sits between the core front end and `i_memory`.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, instruction word width
- `BASE_ADDR`, 32'h00000000, first byte address of instruction memory
- `MEM_DEPTH`, 1024, memory depth in words
- `RESET_PC`, 32'h00000000, fetch PC after reset
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: fetch permitted
- `redirect_valid` in 1: load new fetch PC, flush buffered/in-flight words
- `redirect_pc` in ADDR_WIDTH: new PC; bits [1:0] ignored (masked to 0)
- `mem_addr` out ADDR_WIDTH: to `i_memory.addr`, registered
- `mem_rdata` in DATA_WIDTH: from `i_memory.rdata`
- `instr_valid` out 1: FIFO head valid
- `instr_ready` in 1: core accepts head
- `instr_data` out DATA_WIDTH: head word
- `instr_pc` out ADDR_WIDTH: head address
- `instr_fault` out 1: head address was out of range (data is 0)
- `busy` out 1: FIFO non-empty or read in flight

## Operation
- State machine (`IDLE`, `RUN`, `FAULT`), reset to `IDLE`:
  - `IDLE`→`RUN` when `enable`=1. `RUN`→`IDLE` when `enable`=0.
  - `RUN`→`FAULT` when an issued address is out of range.
  - Any state with `redirect_valid`=1 → `RUN` if `enable` else `IDLE`. Redirect has priority over all other transitions.
- Out-of-range test: `addr < BASE_ADDR` or `addr >= BASE_ADDR + MEM_DEPTH*4`. Compute at ADDR_WIDTH+1 bits so no overflow is possible.
- Issue condition: `issue = (state==RUN) && enable && !redirect_valid && (count + pend - pop) < FIFO_DEPTH`.
  - `pend` is the in-flight flag.
  - `pop = instr_valid && instr_ready`.
- On issue:
  - `pend`←1, `pend_pc`←`mem_addr`, `pend_fault`←range test.
  - `mem_addr`←`mem_addr`+4, modulo 2^ADDR_WIDTH.
  - A faulting issue moves to `FAULT`, and no further issues occur.
- Capture: when `pend`=1 and no redirect, push {`mem_rdata`, `pend_pc`, `pend_fault`} at the clock edge. `pend` clears unless a new issue occurs in the same cycle.
- Pop and push in the same cycle are both honoured. Push never occurs when the FIFO is full; credit guarantees this.
- Redirect in cycle c, applied at the end of c:
  - FIFO emptied, `pend` cleared (in-flight word discarded).
  - `mem_addr`←`redirect_pc & ~3`.
  - A pop in cycle c still completes (core consumed it).
- `instr_data`/`instr_pc`/`instr_fault` reflect the FIFO head and are 0 when `instr_valid`=0.
- `busy = (count != 0) | pend`.
- `enable` low: issuing stops immediately. The in-flight word is still captured, and the FIFO drains normally.

## Timing
- Reset values:
  - `mem_addr`=RESET_PC.
  - `instr_valid`, `instr_data`, `instr_pc`, `instr_fault`, `busy` = 0.
  - FIFO empty, `pend`=0, state `IDLE`.
- Reset asserted mid-operation: immediate return to the reset values, with all buffered and in-flight words lost.
- Issue-to-valid latency: issue in cycle c → `mem_rdata` valid in c+1 → push at end of c+1 → `instr_valid` in c+2.
- `enable` rising in cycle 0 (from `IDLE`): `RUN` in cycle 1, first issue in 1, first `instr_valid` in 3.
- Redirect in cycle c: issue at `redirect_pc` in c+1, `instr_valid` in c+3.
- Throughput: one instruction per cycle sustained while `instr_ready`=1, with `FIFO_DEPTH`=2.
- `instr_ready` low: issues stop once `count + pend` reaches FIFO_DEPTH. No word is dropped or duplicated.

## Structure
- Package `ifetch_pkg` holds:
  - state enum `ifetch_state_t` {IDLE, RUN, FAULT};
  - `WORD_BYTES`=4;
  - the FIFO entry struct {data, pc, fault}.
- Sub-module `ifetch_fifo`: synchronous FIFO, parameterized depth/width, with push, pop, flush (flush wins over push), count, full, empty.
- FSM, PC register, range check and credit logic live in `ifetch_ctrl`.

## Test plan
- Reset release, `enable`=1 at cycle 0, memory words = index, `instr_ready`=1 → `instr_valid` from cycle 3 with pc 0x0,0x4,0x8,…, one per cycle, data 0,1,2,….
- `instr_ready` held low 5 cycles mid-stream → `count`=2, `pend`=0, `mem_addr` frozen. On release, the stream resumes with no gap or duplicate pc.
- Redirect to 0x102 while the FIFO is full and `pend`=1 → FIFO empties next cycle, `mem_addr`=0x100, next `instr_pc`=0x100 valid 3 cycles after the redirect, old words never appear.
- Fetch runs to 0xFFC with MEM_DEPTH=1024 → 0xFFC delivered with fault=0, 0x1000 delivered with fault=1 and data 0. State `FAULT`, no further issues until a redirect to 0x0 restarts fetch at 0x0.
- Redirect and pop in the same cycle → head counted as consumed, flush applied, `busy` falls to 0 for one cycle.
- `reset_n` pulsed low asynchronously mid-stream → all outputs 0 and `mem_addr`=RESET_PC immediately. Fetch restarts per the `enable` rule.
